// File: rtl/encrypt_out_buffer_if.sv
// rtl/encrypt_out_buffer_if.sv - pipeline result capture and output stream bundle
interface encrypt_out_buffer_if #(
    parameter int AW = 4
);
    logic          compute_resq;
    logic [64:0]   encrypt_data;
    logic          encrypt_data_valid;
    logic          issue_ok;
    logic [63:0]   m_data;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic [AW:0]   level;
    logic [15:0]   pkt_cnt;
    logic          overflow;

    // Buffer side
    modport slave (
        input  compute_resq, encrypt_data, encrypt_data_valid, m_ready,
        output issue_ok, m_data, m_last, m_valid, level, pkt_cnt, overflow
    );

    // Request source / consumer side
    modport master (
        output compute_resq, encrypt_data, encrypt_data_valid, m_ready,
        input  issue_ok, m_data, m_last, m_valid, level, pkt_cnt, overflow
    );
endinterface

// File: rtl/encrypt_out_buffer.sv
// rtl/encrypt_out_buffer.sv - credit-protected FWFT buffer behind the encryption pipeline
module encrypt_out_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    encrypt_out_buffer_if.slave   bus
);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] RSV_LIMIT  = (AW+2)'(DEPTH);
    localparam logic [AW+1:0] RSV_MAX    = (AW+2)'(2*DEPTH-1);

    logic [64:0]   mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [AW+1:0] rsv_q, rsv_d;
    logic [15:0]   pkt_cnt_q, pkt_cnt_d;
    logic          overflow_q, overflow_d;

    logic [64:0]   head;
    logic          out_valid;
    logic          full;
    logic          pop;
    logic          push;

    // Head word is read straight from storage so it is visible the cycle after its push
    assign head      = mem[rd_ptr_q];
    assign out_valid = (level_q != '0);
    assign full      = (level_q == LEVEL_FULL);
    assign pop       = out_valid & bus.m_ready;
    // A full buffer still takes a word when a slot frees in the same cycle
    assign push      = bus.encrypt_data_valid & (~full | pop);

    assign bus.m_valid  = out_valid;
    assign bus.m_data   = head[63:0];
    assign bus.m_last   = head[64];
    assign bus.level    = level_q;
    assign bus.pkt_cnt  = pkt_cnt_q;
    assign bus.overflow = overflow_q;
    // Decoded from the reservation register only, never from this cycle's inputs
    assign bus.issue_ok = (rsv_q < RSV_LIMIT);

    // Next-state for pointers, occupancy, reservations and pop-side statistics
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rsv_d      = rsv_q;
        pkt_cnt_d  = pkt_cnt_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end

        if (bus.encrypt_data_valid && full && !pop) begin
            overflow_d = 1'b1;
        end

        // Reservations cover stored words plus words still inside the pipeline
        if (bus.compute_resq && !pop) begin
            if (rsv_q != RSV_MAX) begin
                rsv_d = rsv_q + (AW+2)'(1);
            end
        end else if (pop && !bus.compute_resq) begin
            if (rsv_q != '0) begin
                rsv_d = rsv_q - (AW+2)'(1);
            end
        end

        if (pop && head[64]) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    // Control state with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rsv_q      <= '0;
            pkt_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rsv_q      <= rsv_d;
            pkt_cnt_q  <= pkt_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.encrypt_data;
        end
    end
endmodule

// File: tb/tb_encrypt_out_buffer.sv
// tb/tb_encrypt_out_buffer.sv - directed self-checking bench for encrypt_out_buffer
module tb_encrypt_out_buffer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    encrypt_out_buffer_if #(.AW(4)) bus ();

    encrypt_out_buffer #(.DEPTH(16), .AW(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.compute_resq       = 1'b0;
        bus.encrypt_data       = '0;
        bus.encrypt_data_valid = 1'b0;
        bus.m_ready            = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        step();
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0h expected 0", bus.m_valid); else n_pass++;
        n_checks++; if (bus.issue_ok !== 1'b1) $display("FAIL reset_issue_ok: got %0h expected 1", bus.issue_ok); else n_pass++;
        n_checks++; if (bus.level !== 5'd0) $display("FAIL reset_level: got %0d expected 0", bus.level); else n_pass++;
        n_checks++; if (bus.pkt_cnt !== 16'd0) $display("FAIL reset_pkt_cnt: got %0d expected 0", bus.pkt_cnt); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %0h expected 0", bus.overflow); else n_pass++;
    endtask

    task automatic test_single();
        bus.m_ready            = 1'b1;
        bus.encrypt_data       = {1'b1, 64'h0123456789ABCDEF};
        bus.encrypt_data_valid = 1'b1;
        step();
        bus.encrypt_data_valid = 1'b0;
        n_checks++; if (bus.m_valid !== 1'b1) $display("FAIL single_m_valid: got %0h expected 1", bus.m_valid); else n_pass++;
        n_checks++; if (bus.m_last !== 1'b1) $display("FAIL single_m_last: got %0h expected 1", bus.m_last); else n_pass++;
        n_checks++; if (bus.m_data !== 64'h0123456789ABCDEF) $display("FAIL single_m_data: got %h expected 0123456789abcdef", bus.m_data); else n_pass++;
        step();
        n_checks++; if (bus.pkt_cnt !== 16'd1) $display("FAIL single_pkt_cnt: got %0d expected 1", bus.pkt_cnt); else n_pass++;
        n_checks++; if (bus.level !== 5'd0) $display("FAIL single_level: got %0d expected 0", bus.level); else n_pass++;
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL single_drained: got %0h expected 0", bus.m_valid); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_fill_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.encrypt_data       = {1'b0, 64'(i)};
            bus.encrypt_data_valid = 1'b1;
            step();
        end
        n_checks++; if (bus.level !== 5'd16) $display("FAIL fill_level: got %0d expected 16", bus.level); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL fill_no_overflow: got %0h expected 0", bus.overflow); else n_pass++;
        bus.encrypt_data = {1'b0, 64'd99};
        step();
        bus.encrypt_data_valid = 1'b0;
        n_checks++; if (bus.overflow !== 1'b1) $display("FAIL drop_overflow: got %0h expected 1", bus.overflow); else n_pass++;
        n_checks++; if (bus.level !== 5'd16) $display("FAIL drop_level: got %0d expected 16", bus.level); else n_pass++;
        bus.m_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({bus.m_valid, bus.m_data} !== {1'b1, 64'(i)})
                $display("FAIL drain_word_%0d: got valid=%0h data=%0h expected valid=1 data=%0h", i, bus.m_valid, bus.m_data, i);
            else n_pass++;
            step();
        end
        n_checks++; if (bus.level !== 5'd0) $display("FAIL drain_level: got %0d expected 0", bus.level); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            bus.encrypt_data       = {1'b0, 64'(1000 + i)};
            bus.encrypt_data_valid = 1'b1;
            step();
            n_checks++;
            if ({bus.m_valid, bus.m_data} !== {1'b1, 64'(1000 + i)})
                $display("FAIL wrap_word_%0d: got valid=%0h data=%0h expected valid=1 data=%0h", i, bus.m_valid, bus.m_data, 1000 + i);
            else n_pass++;
        end
        bus.encrypt_data_valid = 1'b0;
        step();
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL wrap_drained: got %0h expected 0", bus.m_valid); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.encrypt_data       = {1'b0, 64'(200 + i)};
            bus.encrypt_data_valid = 1'b1;
            step();
        end
        n_checks++; if (bus.level !== 5'd16) $display("FAIL simul_pre_level: got %0d expected 16", bus.level); else n_pass++;
        bus.m_ready      = 1'b1;
        bus.encrypt_data = {1'b1, 64'hDEADBEEF};
        step();
        bus.encrypt_data_valid = 1'b0;
        n_checks++; if (bus.level !== 5'd16) $display("FAIL simul_level: got %0d expected 16", bus.level); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL simul_overflow: got %0h expected 0", bus.overflow); else n_pass++;
        for (int i = 1; i < 16; i++) begin
            n_checks++;
            if ({bus.m_valid, bus.m_data} !== {1'b1, 64'(200 + i)})
                $display("FAIL simul_word_%0d: got valid=%0h data=%0h expected valid=1 data=%0h", i, bus.m_valid, bus.m_data, 200 + i);
            else n_pass++;
            step();
        end
        n_checks++;
        if ({bus.m_valid, bus.m_last, bus.m_data} !== {1'b1, 1'b1, 64'hDEADBEEF})
            $display("FAIL simul_x: got valid=%0h last=%0h data=%0h expected valid=1 last=1 data=deadbeef", bus.m_valid, bus.m_last, bus.m_data);
        else n_pass++;
        step();
        n_checks++; if (bus.level !== 5'd0) $display("FAIL simul_end_level: got %0d expected 0", bus.level); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_credit();
        logic        pv [5];
        logic [64:0] pd [5];
        logic        req;
        logic        pop;
        int issued = 0, got = 0, cyc = 0, model_rsv = 0, bad_ok = 0, bad_data = 0;
        bit saw_low = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pv[k] = 1'b0;
            pd[k] = '0;
        end
        while (got < 1000 && cyc < 20000) begin
            req = bus.issue_ok && (issued < 1000);
            bus.compute_resq       = req;
            bus.encrypt_data_valid = pv[4];
            bus.encrypt_data       = pd[4];
            for (int k = 4; k > 0; k--) begin
                pv[k] = pv[k-1];
                pd[k] = pd[k-1];
            end
            pv[0] = req;
            pd[0] = {(issued % 4 == 3), 64'(issued)};
            if (req) issued++;
            bus.m_ready = (cyc % 4 == 0);
            #1;
            pop = bus.m_valid && bus.m_ready;
            if (pop) begin
                if ({bus.m_last, bus.m_data} !== {(got % 4 == 3), 64'(got)}) bad_data++;
                got++;
            end
            model_rsv = model_rsv + int'(req) - int'(pop);
            if (!bus.issue_ok) saw_low = 1;
            step();
            if (bus.issue_ok !== (model_rsv < 16)) bad_ok++;
            cyc++;
        end
        idle_inputs();
        n_checks++; if (got !== 1000) $display("FAIL credit_count: got %0d words expected 1000", got); else n_pass++;
        n_checks++; if (bad_data !== 0) $display("FAIL credit_order: got %0d bad words expected 0", bad_data); else n_pass++;
        n_checks++; if (bad_ok !== 0) $display("FAIL credit_issue_ok: got %0d wrong cycles expected 0", bad_ok); else n_pass++;
        n_checks++; if (saw_low !== 1'b1) $display("FAIL credit_throttle: got %0d expected 1", saw_low); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL credit_overflow: got %0h expected 0", bus.overflow); else n_pass++;
    endtask

    task automatic test_pkt_wrap();
        int pushes = 0, pops = 0, cyc = 0;
        do_reset();
        bus.m_ready = 1'b1;
        while (pops < 65537 && cyc < 70000) begin
            bus.encrypt_data_valid = (pushes < 65537);
            bus.encrypt_data       = {1'b1, 64'(pushes)};
            if (pushes < 65537) pushes++;
            if (bus.m_valid && bus.m_ready) pops++;
            step();
            if (pops == 65535) begin
                n_checks++; if (bus.pkt_cnt !== 16'hFFFF) $display("FAIL pkt_ffff: got %h expected ffff", bus.pkt_cnt); else n_pass++;
            end else if (pops == 65536) begin
                n_checks++; if (bus.pkt_cnt !== 16'h0000) $display("FAIL pkt_wrap0: got %h expected 0000", bus.pkt_cnt); else n_pass++;
            end else if (pops == 65537) begin
                n_checks++; if (bus.pkt_cnt !== 16'h0001) $display("FAIL pkt_wrap1: got %h expected 0001", bus.pkt_cnt); else n_pass++;
            end
            cyc++;
        end
        n_checks++; if (pops !== 65537) $display("FAIL pkt_pops: got %0d expected 65537", pops); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            bus.compute_resq       = 1'b1;
            bus.encrypt_data_valid = (i < 7);
            bus.encrypt_data       = {1'b0, 64'(300 + i)};
            step();
        end
        idle_inputs();
        n_checks++; if (bus.level !== 5'd7) $display("FAIL stall_level: got %0d expected 7", bus.level); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.m_valid !== 1'b0) $display("FAIL async_m_valid: got %0h expected 0", bus.m_valid); else n_pass++;
        n_checks++; if (bus.issue_ok !== 1'b1) $display("FAIL async_issue_ok: got %0h expected 1", bus.issue_ok); else n_pass++;
        n_checks++; if (bus.level !== 5'd0) $display("FAIL async_level: got %0d expected 0", bus.level); else n_pass++;
        step();
        reset = 1'b0;
        bus.encrypt_data       = {1'b1, 64'hFEED};
        bus.encrypt_data_valid = 1'b1;
        step();
        bus.encrypt_data_valid = 1'b0;
        n_checks++;
        if ({bus.m_valid, bus.m_last, bus.m_data} !== {1'b1, 1'b1, 64'hFEED})
            $display("FAIL post_reset_word: got valid=%0h last=%0h data=%0h expected valid=1 last=1 data=feed", bus.m_valid, bus.m_last, bus.m_data);
        else n_pass++;
        bus.m_ready = 1'b1;
        step();
        n_checks++; if (bus.level !== 5'd0) $display("FAIL post_reset_level: got %0d expected 0", bus.level); else n_pass++;
        n_checks++; if (bus.pkt_cnt !== 16'd1) $display("FAIL post_reset_pkt: got %0d expected 1", bus.pkt_cnt); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_fill_wrap();
        test_full_simul();
        test_credit();
        test_pkt_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
